// File: rtl/pong_score_keeper.sv
// Match scoring FSM for Pong: point edge detection, score keeping, serve handshake and game-over flag.
// Define WIN_BY_TWO_EN to require a two-point lead to win (with a hard cap at 15).
module pong_score_keeper #(
    parameter int WIN_SCORE   = 7,
    parameter int SERVE_DELAY = 50_000_000
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       PointLeft,
    input  logic       PointRight,
    input  logic       NewGame,
    input  logic       ServeAck,
    output logic [3:0] ScoreLeft,
    output logic [7:0] ScoreRight,
    output logic       BallHold,
    output logic       ServeReq,
    output logic       ServeSide,
    output logic       GameOver,
    output logic       Winner
);

    localparam int               CNT_W     = $clog2(SERVE_DELAY + 1);
    localparam logic [CNT_W-1:0] DELAY_VAL = CNT_W'(SERVE_DELAY);
    localparam logic [3:0]       WIN_VAL   = 4'(WIN_SCORE);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SERVE_WAIT,
        ST_SERVE_REQ,
        ST_PLAY,
        ST_OVER
    } state_t;

    logic             r_rstSync1;
    logic             r_rstSync2;
    logic             w_rstN;
    logic             r_ngSync1;
    logic             r_ngSync2;
    logic             r_ngPrev;
    logic             r_leftPrev;
    logic             r_rightPrev;
    state_t           r_state;
    state_t           w_nextState;
    logic [CNT_W-1:0] r_delayCnt;
    logic [CNT_W-1:0] w_nextDelayCnt;
    logic [3:0]       r_scoreLeft;
    logic [3:0]       r_scoreRight;
    logic [3:0]       w_nextScoreLeft;
    logic [3:0]       w_nextScoreRight;
    logic             r_serveSide;
    logic             w_nextServeSide;
    logic             r_winner;
    logic             w_nextWinner;
    logic             w_newGameEdge;
    logic             w_leftEvt;
    logic             w_rightEvt;
    logic [3:0]       w_leftInc;
    logic [3:0]       w_rightInc;
    logic             w_leftWins;
    logic             w_rightWins;

    // Reset asserts asynchronously but releases only on a clock edge.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_rstSync1 <= 1'b0;
            r_rstSync2 <= 1'b0;
        end else begin
            r_rstSync1 <= 1'b1;
            r_rstSync2 <= r_rstSync1;
        end
    end

    assign w_rstN = r_rstSync2;

    always_ff @(posedge Clk or negedge w_rstN) begin
        if (!w_rstN) begin
            r_ngSync1   <= 1'b0;
            r_ngSync2   <= 1'b0;
            r_ngPrev    <= 1'b0;
            r_leftPrev  <= 1'b0;
            r_rightPrev <= 1'b0;
        end else begin
            r_ngSync1   <= NewGame;
            r_ngSync2   <= r_ngSync1;
            r_ngPrev    <= r_ngSync2;
            r_leftPrev  <= PointLeft;
            r_rightPrev <= PointRight;
        end
    end

    assign w_newGameEdge = r_ngSync2 & ~r_ngPrev;
    assign w_leftEvt     = PointLeft & ~r_leftPrev;
    assign w_rightEvt    = PointRight & ~r_rightPrev;

    assign w_leftInc  = (r_scoreLeft == 4'd15) ? 4'd15 : r_scoreLeft + 4'd1;
    assign w_rightInc = (r_scoreRight == 4'd15) ? 4'd15 : r_scoreRight + 4'd1;

`ifdef WIN_BY_TWO_EN
    // A score of 15 ends the match even without a two-point lead.
    assign w_leftWins  = (w_leftInc == 4'd15) ||
                         ((w_leftInc >= WIN_VAL) && ({1'b0, w_leftInc} >= {1'b0, r_scoreRight} + 5'd2));
    assign w_rightWins = (w_rightInc == 4'd15) ||
                         ((w_rightInc >= WIN_VAL) && ({1'b0, w_rightInc} >= {1'b0, r_scoreLeft} + 5'd2));
`else
    assign w_leftWins  = (w_leftInc >= WIN_VAL);
    assign w_rightWins = (w_rightInc >= WIN_VAL);
`endif

    always_ff @(posedge Clk or negedge w_rstN) begin
        if (!w_rstN) begin
            r_state      <= ST_IDLE;
            r_delayCnt   <= '0;
            r_scoreLeft  <= 4'd0;
            r_scoreRight <= 4'd0;
            r_serveSide  <= 1'b0;
            r_winner     <= 1'b0;
        end else begin
            r_state      <= w_nextState;
            r_delayCnt   <= w_nextDelayCnt;
            r_scoreLeft  <= w_nextScoreLeft;
            r_scoreRight <= w_nextScoreRight;
            r_serveSide  <= w_nextServeSide;
            r_winner     <= w_nextWinner;
        end
    end

    // A new-game edge overrides everything; simultaneous point events cancel out.
    always_comb begin
        w_nextState      = r_state;
        w_nextDelayCnt   = r_delayCnt;
        w_nextScoreLeft  = r_scoreLeft;
        w_nextScoreRight = r_scoreRight;
        w_nextServeSide  = r_serveSide;
        w_nextWinner     = r_winner;
        if (w_newGameEdge) begin
            w_nextState      = ST_SERVE_WAIT;
            w_nextDelayCnt   = DELAY_VAL;
            w_nextScoreLeft  = 4'd0;
            w_nextScoreRight = 4'd0;
            w_nextServeSide  = 1'b0;
            w_nextWinner     = 1'b0;
        end else begin
            case (r_state)
                ST_SERVE_WAIT: begin
                    if (r_delayCnt <= CNT_W'(1)) begin
                        w_nextDelayCnt = '0;
                        w_nextState    = ST_SERVE_REQ;
                    end else begin
                        w_nextDelayCnt = r_delayCnt - CNT_W'(1);
                    end
                end
                ST_SERVE_REQ: begin
                    if (ServeAck) begin
                        w_nextState = ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (w_leftEvt && !w_rightEvt) begin
                        w_nextScoreLeft = w_leftInc;
                        w_nextServeSide = 1'b1;
                        if (w_leftWins) begin
                            w_nextState  = ST_OVER;
                            w_nextWinner = 1'b0;
                        end else begin
                            w_nextState    = ST_SERVE_WAIT;
                            w_nextDelayCnt = DELAY_VAL;
                        end
                    end else if (w_rightEvt && !w_leftEvt) begin
                        w_nextScoreRight = w_rightInc;
                        w_nextServeSide  = 1'b0;
                        if (w_rightWins) begin
                            w_nextState  = ST_OVER;
                            w_nextWinner = 1'b1;
                        end else begin
                            w_nextState    = ST_SERVE_WAIT;
                            w_nextDelayCnt = DELAY_VAL;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ScoreLeft  = r_scoreLeft;
    assign ScoreRight = {4'b0000, r_scoreRight};
    assign BallHold   = (r_state != ST_PLAY);
    assign ServeReq   = (r_state == ST_SERVE_REQ);
    assign ServeSide  = r_serveSide;
    assign GameOver   = (r_state == ST_OVER);
    assign Winner     = r_winner;

endmodule

// File: tb/tb_pong_score_keeper.sv
// Scoreboard bench for pong_score_keeper: a rule-level match model predicts every cycle's outputs.
// Define WIN_BY_TWO_EN for both bench and RTL to exercise the win-by-two rule.
module tb_pong_score_keeper;

    localparam int WIN       = 3;
    localparam int DELAY     = 4;
    localparam int P_IDLE    = 0;
    localparam int P_WAIT    = 1;
    localparam int P_REQ     = 2;
    localparam int P_PLAY    = 3;
    localparam int P_OVER    = 4;
    localparam logic [16:0] RESET_VEC = {4'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b0;
    logic       PointLeft = 1'b0;
    logic       PointRight = 1'b0;
    logic       NewGame = 1'b0;
    logic       ServeAck = 1'b0;
    logic [3:0] ScoreLeft;
    logic [7:0] ScoreRight;
    logic       BallHold;
    logic       ServeReq;
    logic       ServeSide;
    logic       GameOver;
    logic       Winner;
    logic [16:0] dutVec;

    int checks = 0;
    int failures = 0;
    bit monEn = 1'b0;
    logic [16:0] expQ[$];

    int mL, mR, mSide, mWin, mPhase, mWait;
    int ngH0, ngH1, ngH2, plPrev, prPrev;

    pong_score_keeper #(.WIN_SCORE(WIN), .SERVE_DELAY(DELAY)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .PointLeft(PointLeft), .PointRight(PointRight),
        .NewGame(NewGame), .ServeAck(ServeAck), .ScoreLeft(ScoreLeft), .ScoreRight(ScoreRight),
        .BallHold(BallHold), .ServeReq(ServeReq), .ServeSide(ServeSide),
        .GameOver(GameOver), .Winner(Winner)
    );

    always #5 Clk = ~Clk;

    assign dutVec = {ScoreLeft, ScoreRight, BallHold, ServeReq, ServeSide, GameOver, Winner};

    task automatic checkOutput(input string name, input logic [16:0] actual, input logic [16:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h (L,R8,hold,req,side,over,win) t=%0t",
                     name, actual, required, $time);
        end
    endtask

    function automatic bit won(input int s, input int o);
`ifdef WIN_BY_TWO_EN
        return (s >= 15) || (s >= WIN && s - o >= 2);
`else
        return (o < 0) ? 1'b0 : (s >= WIN);
`endif
    endfunction

    function automatic logic [16:0] expVec();
        return {4'(mL), 8'(mR), mPhase != P_PLAY, mPhase == P_REQ, 1'(mSide), mPhase == P_OVER, 1'(mWin)};
    endfunction

    task automatic modelReset();
        mL = 0; mR = 0; mSide = 0; mWin = 0; mPhase = P_IDLE; mWait = 0;
        ngH0 = 0; ngH1 = 0; ngH2 = 0; plPrev = 0; prPrev = 0;
    endtask

    // One clock edge of the match rules; NewGame is seen two edges late through its synchroniser.
    task automatic modelStep(input int pl, input int pr, input int ng, input int ack);
        int ngEdge, le, re;
        ngEdge = (ngH1 == 1 && ngH2 == 0) ? 1 : 0;
        le = (pl == 1 && plPrev == 0) ? 1 : 0;
        re = (pr == 1 && prPrev == 0) ? 1 : 0;
        ngH2 = ngH1; ngH1 = ngH0; ngH0 = ng; plPrev = pl; prPrev = pr;
        if (ngEdge == 1) begin
            mL = 0; mR = 0; mWin = 0; mSide = 0; mPhase = P_WAIT; mWait = DELAY;
        end else if (mPhase == P_WAIT) begin
            mWait--;
            if (mWait == 0) mPhase = P_REQ;
        end else if (mPhase == P_REQ) begin
            if (ack == 1) mPhase = P_PLAY;
        end else if (mPhase == P_PLAY && (le + re) == 1) begin
            if (le == 1) begin
                mL = (mL < 15) ? mL + 1 : 15;
                mSide = 1;
                if (won(mL, mR)) begin mPhase = P_OVER; mWin = 0; end
                else begin mPhase = P_WAIT; mWait = DELAY; end
            end else begin
                mR = (mR < 15) ? mR + 1 : 15;
                mSide = 0;
                if (won(mR, mL)) begin mPhase = P_OVER; mWin = 1; end
                else begin mPhase = P_WAIT; mWait = DELAY; end
            end
        end
    endtask

    // Inputs change 1 time unit after a rising edge; the prediction is queued at the next edge.
    task automatic applyStimulus(input int pl, input int pr, input int ng, input int ack);
        PointLeft = 1'(pl); PointRight = 1'(pr); NewGame = 1'(ng); ServeAck = 1'(ack);
        @(posedge Clk);
        modelStep(pl, pr, ng, ack);
        if (monEn) expQ.push_back(expVec());
        #1;
    endtask

    task automatic doReset();
        @(negedge Clk);
        #1;
        Rst_n = 1'b0;
        monEn = 1'b0;
        expQ.delete();
        PointLeft = 1'b0; PointRight = 1'b0; NewGame = 1'b0; ServeAck = 1'b0;
        #1 checkOutput("asyncReset", dutVec, RESET_VEC);
        for (int i = 0; i < 2; i++) begin
            PointLeft = 1'(i == 0);
            @(posedge Clk);
            #1 checkOutput("pointDuringReset", dutVec, RESET_VEC);
        end
        PointLeft = 1'b0;
        Rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge Clk);
            #1 checkOutput("afterRelease", dutVec, RESET_VEC);
        end
        modelReset();
        monEn = 1'b1;
    endtask

    task automatic serveBall();
        for (int i = 0; i < 40 && mPhase != P_REQ; i++) applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1);
    endtask

    task automatic newGame();
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0);
        serveBall();
    endtask

    task automatic point(input int left);
        applyStimulus(left, 1 - left, 0, 0);
        applyStimulus(0, 0, 0, 0);
        if (mPhase != P_OVER) serveBall();
    endtask

    always @(negedge Clk) begin
        if (monEn && expQ.size() > 0) checkOutput("cycleOutputs", dutVec, expQ.pop_front());
    end

    initial begin
        int rpl, rpr, rng;
        modelReset();
        doReset();

        // Reach 2-1 in play, then reset asynchronously and show a point is ignored in IDLE.
        newGame();
        point(1); point(1); point(0);
        doReset();
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);

        // Serve delay, long wait for ServeAck, then launch.
        applyStimulus(0, 0, 1, 0);
        for (int i = 0; i < 40 && mPhase != P_REQ; i++) applyStimulus(0, 0, 0, 0);
        repeat (10) applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0);

        // Held-high left point scores once; right pulses during the serve pause are dropped.
        for (int i = 0; i < 20; i++) applyStimulus(1, (i == 2 || i == 4) ? 1 : 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        serveBall();

        // Simultaneous rises cancel.
        repeat (3) applyStimulus(1, 1, 0, 0);
        applyStimulus(0, 0, 0, 0);

        // Right wins 1-3, further points ignored, NewGame clears.
        point(0); point(0); point(0);
        applyStimulus(1, 0, 0, 0); applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0); applyStimulus(0, 0, 0, 0);
        newGame();
        repeat (3) applyStimulus(0, 0, 0, 0);

`ifdef WIN_BY_TWO_EN
        newGame();
        point(1); point(0); point(1); point(0); point(1); point(1);
        newGame();
        for (int i = 0; i < 14; i++) begin point(1); point(0); end
        point(1);
`endif

        // Randomised play.
        rpl = 0; rpr = 0; rng = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) rpl = 1 - rpl;
            if ($urandom_range(0, 3) == 0) rpr = 1 - rpr;
            if ($urandom_range(0, 59) == 0) rng = 1 - rng;
            applyStimulus(rpl, rpr, rng, ($urandom_range(0, 2) == 0) ? 1 : 0);
        end

        applyStimulus(0, 0, 0, 0);
        @(negedge Clk);
        #1;
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboardDrain actual=%0d required=0", expQ.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
